// File: rtl/alu_types_pkg.sv
// Shared opcode encoding for the pipelined ALU and its interface.
package alu_types_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    XOR = 3'd3,
    ACC = 3'd4,
    CLR = 3'd5
  } operation_t;

  // Any encoding above this is an illegal opcode.
  localparam operation_t OP_LAST = CLR;

endpackage

// File: rtl/alu_interface.sv
// Bundle of ALU request/response signals with handshakes, plus a clocking view for drivers.
interface alu_interface
  import alu_types_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input logic clk
);

  logic             rst;
  operation_t       op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   out;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  clocking cb @(posedge clk);
    output rst, op_in, a_in, b_in, in_valid, out_ready;
    input  in_ready, out, out_err, out_valid;
  endclocking

  modport dut (
    input  clk, rst, op_in, a_in, b_in, in_valid, out_ready,
    output in_ready, out, out_err, out_valid
  );

endinterface

// File: rtl/alu_pipe_stage.sv
// One enable-gated pipeline slot carrying {valid, result, err}.
module alu_pipe_stage #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] result_i,
  input  logic         err_i,
  output logic         valid_o,
  output logic [W-1:0] result_o,
  output logic         err_o
);

  logic         valid_q;
  logic [W-1:0] result_q;
  logic         err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (en_i) begin
      valid_q  <= valid_i;
      result_q <= result_i;
      err_q    <= err_i;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign err_o    = err_q;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: decode and accumulator feed a LATENCY-deep shift pipe that stalls as a whole.
module alu_pipe
  import alu_types_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  operation_t       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   out,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned RW = WIDTH + 1;

  logic          en_c;
  logic          accept_c;
  logic [RW-1:0] a_ext_c;
  logic [RW-1:0] b_ext_c;
  logic [RW-1:0] result_c;
  logic          err_c;
  logic [RW-1:0] acc_d;
  logic [RW-1:0] acc_q;

  logic          stage_valid  [LATENCY+1];
  logic [RW-1:0] stage_result [LATENCY+1];
  logic          stage_err    [LATENCY+1];

  // The whole pipe advances unless the last slot holds an untaken result.
  assign en_c     = !out_valid || out_ready;
  assign in_ready = en_c && !rst;
  assign accept_c = in_valid && in_ready;

  assign a_ext_c = RW'(a_in);
  assign b_ext_c = RW'(b_in);

  always_comb begin
    result_c = '0;
    err_c    = (op_in > OP_LAST);
    acc_d    = acc_q;
    case (op_in)
      ADD: result_c = a_ext_c + b_ext_c;
      SUB: result_c = a_ext_c - b_ext_c;
      AND: result_c = a_ext_c & b_ext_c;
      XOR: result_c = a_ext_c ^ b_ext_c;
      ACC: begin
        result_c = acc_q + a_ext_c;
        acc_d    = acc_q + a_ext_c;
      end
      CLR: begin
        result_c = acc_q;
        acc_d    = '0;
      end
      default: result_c = '0;
    endcase
  end

  // Accumulator commits only on acceptance, so back-to-back ACC/CLR chain naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (accept_c) begin
      acc_q <= acc_d;
    end
  end

  assign stage_valid[0]  = accept_c;
  assign stage_result[0] = result_c;
  assign stage_err[0]    = err_c;

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    alu_pipe_stage #(
      .W (RW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en_c),
      .valid_i  (stage_valid[s]),
      .result_i (stage_result[s]),
      .err_i    (stage_err[s]),
      .valid_o  (stage_valid[s+1]),
      .result_o (stage_result[s+1]),
      .err_o    (stage_err[s+1])
    );
  end

  assign out_valid = stage_valid[LATENCY];
  assign out       = stage_result[LATENCY];
  assign out_err   = stage_err[LATENCY];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three latency builds share stimulus; each is scored against an in-order reference queue.
module tb_alu_pipe;
  import alu_types_pkg::*;

  localparam int unsigned W    = 6;
  localparam int          MODV = 128;
  localparam int          NI   = 3;
  localparam int          QD   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       out_ready;
  operation_t op;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic [NI-1:0] ir;
  logic [NI-1:0] ov;
  logic [NI-1:0] oe;
  logic [W:0]    ot [NI];

  alu_pipe #(.WIDTH(W), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .op_in(op), .a_in(a), .b_in(b), .in_valid(in_valid),
    .in_ready(ir[0]), .out(ot[0]), .out_err(oe[0]), .out_valid(ov[0]), .out_ready(out_ready));
  alu_pipe #(.WIDTH(W), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .op_in(op), .a_in(a), .b_in(b), .in_valid(in_valid),
    .in_ready(ir[1]), .out(ot[1]), .out_err(oe[1]), .out_valid(ov[1]), .out_ready(out_ready));
  alu_pipe #(.WIDTH(W), .LATENCY(8)) u_l8 (
    .clk(clk), .rst(rst), .op_in(op), .a_in(a), .b_in(b), .in_valid(in_valid),
    .in_ready(ir[2]), .out(ot[2]), .out_err(oe[2]), .out_valid(ov[2]), .out_ready(out_ready));

  int total;
  int bad;
  int cyc;

  // Reference state per build: expected results in acceptance order.
  int q_res [NI][QD];
  int q_err [NI][QD];
  int q_cyc [NI][QD];
  int q_stl [NI][QD];
  int hd    [NI];
  int cnt   [NI];
  int m_acc [NI];
  int stl   [NI];
  bit seen  [NI];
  bit p_stall [NI];
  logic [W:0] p_out [NI];
  logic       p_err [NI];
  bit p_rst;

  bit          snap_ov   [NI];
  bit          snap_ir   [NI];
  bit          snap_err  [NI];
  bit          snap_acc  [NI];
  bit          snap_xfer [NI];
  logic [31:0] snap_out  [NI];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Arithmetic reference of the opcode table; acc is the model accumulator.
  function automatic int ref_op(input int opc, input int av, input int bv,
                                inout int acc, output int err);
    int r;
    err = 0;
    r   = 0;
    case (opc)
      0: r = (av + bv) % MODV;
      1: r = (av - bv + MODV) % MODV;
      2: r = av & bv;
      3: r = av ^ bv;
      4: begin acc = (acc + av) % MODV; r = acc; end
      5: begin r = acc; acc = 0; end
      default: begin r = 0; err = 1; end
    endcase
    return r;
  endfunction

  task automatic monitor();
    int r;
    int e;
    int idx;
    for (int k = 0; k < NI; k++) begin
      string sfx;
      sfx = $sformatf("[L%0d]", lat_of(k));
      chk({"in_ready", sfx}, 32'(ir[k]), 32'(!rst && (!ov[k] || out_ready)));
      if (p_rst)
        chk({"reset_state", sfx}, 32'({ov[k], oe[k], ot[k]}), 32'd0);
      else if (p_stall[k])
        chk({"stall_hold", sfx}, 32'({ov[k], oe[k], ot[k]}), 32'({1'b1, p_err[k], p_out[k]}));

      snap_ov[k]   = ov[k];
      snap_ir[k]   = ir[k];
      snap_err[k]  = oe[k];
      snap_out[k]  = 32'(ot[k]);
      snap_acc[k]  = !rst && in_valid && ir[k];
      snap_xfer[k] = !rst && ov[k] && out_ready;

      if (rst) begin
        cnt[k]     = 0;
        hd[k]      = 0;
        m_acc[k]   = 0;
        seen[k]    = 1'b0;
        p_stall[k] = 1'b0;
      end else begin
        if (ov[k] && !seen[k]) begin
          chk({"spurious_valid", sfx}, 32'(cnt[k] > 0), 32'd1);
          if (cnt[k] > 0)
            chk({"latency", sfx}, 32'(cyc - q_cyc[k][hd[k]]),
                32'(lat_of(k) + stl[k] - q_stl[k][hd[k]]));
          seen[k] = 1'b1;
        end
        if (ov[k] && out_ready && cnt[k] > 0) begin
          chk({"result", sfx}, 32'(ot[k]), 32'(q_res[k][hd[k]]));
          chk({"err", sfx}, 32'(oe[k]), 32'(q_err[k][hd[k]]));
          hd[k]   = (hd[k] + 1) % QD;
          cnt[k]  = cnt[k] - 1;
          seen[k] = 1'b0;
        end
        p_stall[k] = ov[k] && !out_ready;
        if (p_stall[k]) stl[k]++;
        if (in_valid && ir[k]) begin
          r   = ref_op(int'(op), int'(a), int'(b), m_acc[k], e);
          idx = (hd[k] + cnt[k]) % QD;
          q_res[k][idx] = r;
          q_err[k][idx] = e;
          q_cyc[k][idx] = cyc;
          q_stl[k][idx] = stl[k];
          cnt[k] = cnt[k] + 1;
        end
      end
      p_out[k] = ot[k];
      p_err[k] = oe[k];
    end
    p_rst = rst;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input int opc, input int av, input int bv);
    op       = operation_t'(3'(opc));
    a        = 6'(av);
    b        = 6'(bv);
    in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (snap_acc[0]) break;
    end
    chk("accept", 32'(snap_acc[0]), 32'd1);
    in_valid = 1'b0;
  endtask

  // Single request into an empty pipe: nothing after one edge, result after two.
  task automatic run_one(input int opc, input int av, input int bv,
                         input int exp, input int experr, input string tag);
    issue(opc, av, bv);
    tick();
    chk({tag, "_early"}, 32'(snap_ov[0]), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(snap_ov[0]), 32'd1);
    chk({tag, "_out"}, snap_out[0], 32'(exp));
    chk({tag, "_err"}, 32'(snap_err[0]), 32'(experr));
  endtask

  initial begin
    int i;
    int got[$];
    total = 0; bad = 0; cyc = 0; p_rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      hd[k] = 0; cnt[k] = 0; m_acc[k] = 0; stl[k] = 0; seen[k] = 1'b0; p_stall[k] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = ADD; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", 32'(snap_ov[0]), 32'd0);
    chk("rst_out", snap_out[0], 32'd0);
    chk("rst_out_err", 32'(snap_err[0]), 32'd0);
    chk("rst_in_ready", 32'(snap_ir[0]), 32'd1);

    run_one(0, 63, 1, 64, 0, "add_carry");
    run_one(1, 0, 1, 127, 0, "sub_borrow");
    run_one(2, 'h2A, 'h0F, 'h0A, 0, "and");

    op = ACC; in_valid = 1'b1; a = 6'd10;
    tick();
    a = 6'd20;
    tick();
    a = 6'd40;
    tick();
    chk("acc_10", snap_out[0], 32'd10);
    in_valid = 1'b0;
    tick();
    chk("acc_30", snap_out[0], 32'd30);
    tick();
    chk("acc_70", snap_out[0], 32'd70);
    chk("acc_70_valid", 32'(snap_ov[0]), 32'd1);

    run_one(5, 0, 0, 70, 0, "clr");
    run_one(4, 5, 0, 5, 0, "acc_after_clr");
    run_one(4, 63, 0, 68, 0, "acc_63a");
    run_one(4, 63, 0, 3, 0, "acc_wrap");
    run_one(6, 1, 1, 0, 1, "illegal");
    run_one(4, 0, 0, 3, 0, "acc_unchanged");

    // Stream six ADDs and stall the consumer for five cycles from the first result.
    i = 0; op = ADD;
    for (int j = 0; j < 25; j++) begin
      in_valid  = (i < 6);
      a         = 6'(i);
      b         = 6'(i);
      out_ready = !(j >= 2 && j <= 6);
      tick();
      if (snap_acc[0]) i++;
      if (j >= 2 && j <= 6) begin
        chk("stall_in_ready", 32'(snap_ir[0]), 32'd0);
        chk("stall_valid", 32'(snap_ov[0]), 32'd1);
        chk("stall_out", snap_out[0], 32'd0);
      end
      if (snap_xfer[0]) got.push_back(int'(snap_out[0]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(got.size()), 32'd6);
    for (int n = 0; n < 6; n++)
      if (n < got.size()) chk($sformatf("stream_order%0d", n), 32'(got[n]), 32'(2 * n));

    // Reset with two accumulator results in flight.
    run_one(5, 0, 0, 3, 0, "clr_pre_rst");
    out_ready = 1'b0; op = ACC; in_valid = 1'b1; a = 6'd10;
    tick();
    chk("rst_flight_a", 32'(snap_acc[0]), 32'd1);
    a = 6'd20;
    tick();
    chk("rst_flight_b", 32'(snap_acc[0]), 32'd1);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("rst_discard", 32'(snap_ov[0]), 32'd0);
    end
    run_one(4, 1, 0, 1, 0, "acc_after_rst");

    // Randomised traffic with random backpressure and occasional reset.
    for (int t = 0; t < 800; t++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 9) < ((t < 400) ? 8 : 4));
      out_ready = ($urandom_range(0, 9) < ((t < 400) ? 5 : 9));
      op        = operation_t'(3'($urandom_range(0, 7)));
      a         = 6'($urandom_range(0, 63));
      b         = 6'($urandom_range(0, 63));
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (15) tick();
    for (int k = 0; k < NI; k++)
      chk($sformatf("drained[L%0d]", lat_of(k)), 32'(cnt[k]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the single-cycle ALU. It accepts one operation per cycle over a valid/ready handshake and returns the result a fixed number of cycles later, with full output backpressure. It adds subtract, a running accumulator and illegal-opcode flagging. It sits between the stimulus/driver side of the datapath and any downstream consumer that can stall.

## Interface
- `WIDTH`, default 6: operand width; results are `WIDTH+1` bits.
- `LATENCY`, default 2, legal range 1..8: pipeline register stages from acceptance to `out`.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `op_in` input, `operation_t`: opcode, sampled on acceptance.
- `a_in` input, WIDTH bits: operand A.
- `b_in` input, WIDTH bits: operand B.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: the block accepts the request this cycle.
- `out` output, WIDTH+1 bits: result.
- `out_err` output, 1 bit: the result came from an illegal opcode.
- `out_valid` output, 1 bit: `out` and `out_err` are valid.
- `out_ready` input, 1 bit: the consumer takes the result this cycle.

## Operation
- Acceptance: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready`.
- Results are computed combinationally from the accepted inputs and enter stage 1. Stages 2..LATENCY only carry `{valid, result, err}`.
- Opcodes (3-bit `operation_t`):
  - ADD=0: `out = {1'b0,a} + {1'b0,b}`; bit WIDTH is the carry.
  - SUB=1: `out = ({1'b0,a} - {1'b0,b}) mod 2^(WIDTH+1)`; bit WIDTH is the borrow.
  - AND=2, XOR=3: bitwise result, zero-extended.
  - ACC=4: `out = acc + a`, and `acc <= acc + a`. `acc` is WIDTH+1 bits and wraps mod 2^(WIDTH+1). `b` is ignored.
  - CLR=5: `out = acc` (the pre-clear value), and `acc <= 0`.
  - 6 and 7 are illegal: `out = 0`, `err = 1`, `acc` unchanged.
- `acc` updates only on acceptance. Back-to-back ACC/CLR see the updated value with no hazard.
- Results leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset: all stage valid bits, `out`, `out_err`, `out_valid` and `acc` are 0 on the cycle after `rst` is sampled high. `in_ready` is 1 while `rst` is low and the pipe is empty.
- `rst` is high: `in_ready` = 0 and no acceptance occurs. A reset during operation discards every in-flight result; no `out_valid` appears for them.
- Global advance enable: `en = !out_valid || out_ready`. `in_ready = en && !rst`.
- When `en` is 1, every stage shifts by one and stage 1 loads the new request, or a bubble if there is no acceptance.
- When `en` is 0, all stages hold; `out`, `out_err` and `out_valid` stay stable until transfer.
- Without stalls, a request accepted at edge N appears with `out_valid` = 1 after edge N+LATENCY-1, so it is available for transfer at edge N+LATENCY. Throughput is 1 per cycle.
- A simultaneous transfer and acceptance in the same cycle is legal and loses nothing.
- `out_valid` falls after a transfer unless a valid result shifts into the last stage.
- Bubbles do not collapse; `in_ready` depends only on last-stage occupancy and `out_ready`.

## Structure
- `alu_types_pkg` holds the `operation_t` enum (3 bits: ADD, SUB, AND, XOR, ACC, CLR) and the constant `OP_LAST = CLR` used for the illegal-opcode check.
- Sub-module `alu_pipe_stage`: a single enable-gated register `{valid, result, err}`, parametrised on width and instantiated LATENCY times with a generate loop. Opcode decode and the accumulator live in the top module.
- The existing `alu_interface` is extended with `in_ready`, `out_ready` and `out_err`, and with clocking-block entries for each.

## Test plan
- WIDTH=6, LATENCY=2, `out_ready`=1. Issue ADD 63+1 -> `out`=64 with `out_valid`=1, exactly 2 cycles after acceptance. Issue SUB 0-1 -> `out`=127. Issue AND 0x2A,0x0F -> `out`=0x0A.
- ACC with a=10, 20, 40 back-to-back -> `out`=10, 30, 70 on consecutive cycles. Then CLR -> `out`=70. Then ACC a=5 -> `out`=5. Then ACC a=63 twice -> `out`=68, then 3 (wrap mod 128).
- Drive `op_in`=6 with a=1, b=1 -> `out`=0 and `out_err`=1, and a following ACC 0 shows `acc` unchanged.
- Stream 6 back-to-back ADDs (a=i, b=i) while holding `out_ready`=0 for 5 cycles starting at the first `out_valid`:
  - `in_ready` drops to 0;
  - `out` holds at 0 while stalled;
  - after release, the results appear in order 0, 2, 4, 6, 8, 10 with no loss.
- Assert `rst` for 1 cycle with 2 results in flight and `acc`=30 -> no `out_valid` for those results. After reset, ACC a=1 -> `out`=1.
- LATENCY=1 and LATENCY=8 builds, with randomised `in_valid`/`out_ready` duty cycles -> the scoreboard matches the reference model in order, and the latency under no stall equals LATENCY.
